alu_pipe_datapath: RTL and testbench
====================================

Name: alu_pipe_datapath

Overview:
- Parametrised successor of the single-cycle ALU/register-file datapath.
- Contents: NREGS x WIDTH register file, operand select, two-stage pipelined ALU with internal writeback, one-path result forwarding, and an iterative multiply that stalls issue.
- Sits between instruction decode (issue side) and the branch/writeback consumers.
- External write port lets the load path update registers.

Parameters:
- WIDTH, 16, datapath and register width in bits (>=4).
- NREGS, 8, number of registers (power of two, >=2).
- AW, $clog2(NREGS), register address width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  issue request
- in_ready  out  1  datapath accepts issue this cycle
- rs1_addr  in  AW  operand A register
- rs2_addr  in  AW  operand B register
- rd_addr  in  AW  destination register
- wr_en  in  1  write ALU result to rd_addr
- alu_op  in  4  operation code
- src1_zero  in  1  1: operand A = 0
- src2_imm  in  1  1: operand B = imm
- imm  in  WIDTH  immediate operand
- ext_wr_en  in  1  external register write
- ext_wr_addr  in  AW  external write address
- ext_wr_data  in  WIDTH  external write data
- out_valid  out  1  result/flags valid, one-cycle pulse
- result  out  WIDTH  registered ALU result
- ovf  out  1  registered overflow flag
- take_branch  out  1  registered branch decision

Behaviour:
- Reset (async, rst=1): all registers, result, ovf, take_branch, out_valid and the execute stage clear to 0; FSM -> IDLE; in_ready=1 once rst deasserts. Reset mid-multiply abandons the operation; no writeback occurs.
- Register 0 always reads 0; writes to it are ignored.
- Issue: handshake at a rising edge with in_valid & in_ready.
  - Operands are read combinationally in the issue cycle.
  - Read priority, highest first: (1) execute-stage forward, if the execute stage is valid with a writing op and its rd equals rs and is nonzero; (2) ext_wr_data, if ext_wr_en and ext_wr_addr equal rs; (3) register array.
  - src1_zero and src2_imm are applied after forwarding.
- Pipeline timing for single-cycle ops, issued in cycle T:
  - Operands captured at the end of T.
  - ALU evaluates in T+1.
  - At the end of T+1: result, ovf and take_branch are registered, and writeback occurs.
  - out_valid=1 in cycle T+2 only.
- Throughput: one single-cycle op per cycle; back-to-back dependent ops need no stall.
- Writeback is performed when wr_en=1, rd!=0 and op is not 6 or 7.
  - If the internal writeback and ext_wr target the same register in the same cycle, the internal writeback wins.
  - Writes to different registers both occur.
- Ops (a = operand A, b = operand B, f = result, all WIDTH bits):
  - 0: f = a+b; ovf is signed overflow.
  - 1: f = ~b.
  - 2: f = a&b.
  - 3: f = a|b.
  - 4: f = a>>>b (arithmetic); if b>=WIDTH, f = all sign bits.
  - 5: f = a<<b; if b>=WIDTH, f = 0.
  - 6: take_branch = (a==0); f=0.
  - 7: take_branch = (a!=0); f=0.
  - 8: f = a^b.
  - 9: f = low WIDTH bits of unsigned a*b; ovf=1 if the upper WIDTH bits are nonzero.
  - 10: f = a-b; ovf is signed overflow.
  - 11-15: f=0.
  - ovf and take_branch are 0 unless their op sets them.
- Multiply FSM, IDLE -> MUL -> IDLE:
  - Op 9 issued in T enters MUL at the end of T.
  - Shift-add, one bit per cycle, WIDTH iterations: T+1 .. T+WIDTH.
  - in_ready=0 from T+1 through T+WIDTH.
  - Result and writeback are registered at the end of T+WIDTH.
  - out_valid in T+WIDTH+1; in_ready returns to 1 in T+WIDTH+1.
  - A single-cycle op already in the execute stage when MUL issues completes normally.
- in_valid while in_ready=0 is ignored; there is no queueing.
- ext_wr writes are accepted every cycle, including during MUL.

Test Plan:
- Reset, then ext_wr r1=0x7FFF and r2=0x0001; issue op0 rd=r3 -> in T+2: out_valid=1, result=0x8000, ovf=1; then r3 reads 0x8000.
- Back-to-back: op0 r3=r1+r2 (r1=5, r2=6), next cycle op10 r4=r3-r1 -> second result=0x0006 with no stall, confirming the forward path.
- MUL: r1=0x0100, r2=0x0100, op9 -> in_ready low for 16 cycles; result=0x0000, ovf=1, out_valid in T+17; r1=3, r2=7 -> result=21, ovf=0.
- Branch and shift: op6 with r0 -> take_branch=1, no writeback; op4 a=0x8000, b=imm 20 -> 0xFFFF; op5 with b=16 -> 0.
- Collisions: write to r0 -> r0 still reads 0; ext_wr and internal writeback both to r5 in the same cycle -> r5 holds the ALU result.
- Assert rst in cycle 8 of a MUL -> all outputs 0 immediately, no writeback; after release in_ready=1.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Issue, external-write and result bundle for alu_pipe_datapath.
// The decode/load side drives through master; the datapath sits on slave.
interface alu_pipe_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
);
    localparam int AW = $clog2(NREGS);

    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    rs1_addr;
    logic [AW-1:0]    rs2_addr;
    logic [AW-1:0]    rd_addr;
    logic             wr_en;
    logic [3:0]       alu_op;
    logic             src1_zero;
    logic             src2_imm;
    logic [WIDTH-1:0] imm;
    logic             ext_wr_en;
    logic [AW-1:0]    ext_wr_addr;
    logic [WIDTH-1:0] ext_wr_data;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             take_branch;

    modport master (
        output in_valid, rs1_addr, rs2_addr, rd_addr, wr_en, alu_op,
               src1_zero, src2_imm, imm, ext_wr_en, ext_wr_addr, ext_wr_data,
        input  in_ready, out_valid, result, ovf, take_branch
    );

    modport slave (
        input  in_valid, rs1_addr, rs2_addr, rd_addr, wr_en, alu_op,
               src1_zero, src2_imm, imm, ext_wr_en, ext_wr_addr, ext_wr_data,
        output in_ready, out_valid, result, ovf, take_branch
    );
endinterface

// File: rtl/alu_pipe_datapath.sv
// Register file + two-stage ALU pipeline with execute-stage forwarding and an
// iterative shift-add multiplier that holds off issue while it runs.
module alu_pipe_datapath #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic     clk,
    input  logic     rst,
    alu_pipe_if.slave bus
);
    localparam int AW  = $clog2(NREGS);
    localparam int CW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef logic [WIDTH-1:0]   word_t;
    typedef logic [2*WIDTH-1:0] dword_t;
    typedef logic [AW-1:0]      addr_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_NOT = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
        OP_SRA = 4'd4, OP_SLL = 4'd5, OP_BEQZ = 4'd6, OP_BNEZ = 4'd7,
        OP_XOR = 4'd8, OP_MUL = 4'd9, OP_SUB = 4'd10
    } op_t;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    localparam word_t W_LIMIT = word_t'(WIDTH);

    word_t  regs [NREGS];
    state_t state, state_nxt;

    logic   ex_valid, ex_wr;
    op_t    ex_op;
    word_t  ex_a, ex_b;
    addr_t  ex_rd;

    dword_t mul_acc, mul_mcand, mul_acc_nxt;
    word_t  mul_mplier;
    logic [CW-1:0] mul_cnt;
    addr_t  mul_rd;
    logic   mul_wr, mul_last, mul_done;

    word_t  alu_f;
    logic   alu_ovf, alu_br;
    word_t  opa, opb;
    logic   fire, issue_mul, issue_wr;
    op_t    issue_op;

    function automatic word_t pick_operand(
        input addr_t rs, input logic fwd_en, input addr_t fwd_rd, input word_t fwd_data,
        input logic ext_en, input addr_t ext_addr, input word_t ext_data, input word_t reg_data);
        if (rs == '0)                        return '0;
        if (fwd_en && fwd_rd == rs)          return fwd_data;
        if (ext_en && ext_addr == rs)        return ext_data;
        return reg_data;
    endfunction

    // Issue-side operand fetch with forwarding, then zero/immediate substitution.
    always_comb begin
        issue_op  = op_t'(bus.alu_op);
        fire      = bus.in_valid & bus.in_ready;
        issue_mul = fire && (issue_op == OP_MUL);
        issue_wr  = bus.wr_en && (bus.rd_addr != '0) &&
                    (issue_op != OP_BEQZ) && (issue_op != OP_BNEZ);
        opa = pick_operand(bus.rs1_addr, ex_valid & ex_wr, ex_rd, alu_f,
                           bus.ext_wr_en, bus.ext_wr_addr, bus.ext_wr_data, regs[bus.rs1_addr]);
        opb = pick_operand(bus.rs2_addr, ex_valid & ex_wr, ex_rd, alu_f,
                           bus.ext_wr_en, bus.ext_wr_addr, bus.ext_wr_data, regs[bus.rs2_addr]);
        if (bus.src1_zero) opa = '0;
        if (bus.src2_imm)  opb = bus.imm;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_wr    <= 1'b0;
            ex_op    <= OP_ADD;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_rd    <= '0;
        end else begin
            ex_valid <= fire && !issue_mul;
            if (fire) begin
                ex_wr <= issue_wr;
                ex_op <= issue_op;
                ex_a  <= opa;
                ex_b  <= opb;
                ex_rd <= bus.rd_addr;
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        alu_f   = '0;
        alu_ovf = 1'b0;
        alu_br  = 1'b0;
        case (ex_op)
            OP_ADD: begin
                alu_f   = ex_a + ex_b;
                alu_ovf = (ex_a[MSB] == ex_b[MSB]) && (alu_f[MSB] != ex_a[MSB]);
            end
            OP_SUB: begin
                alu_f   = ex_a - ex_b;
                alu_ovf = (ex_a[MSB] != ex_b[MSB]) && (alu_f[MSB] != ex_a[MSB]);
            end
            OP_NOT:  alu_f = ~ex_b;
            OP_AND:  alu_f = ex_a & ex_b;
            OP_OR:   alu_f = ex_a | ex_b;
            OP_XOR:  alu_f = ex_a ^ ex_b;
            OP_SRA:  alu_f = (ex_b >= W_LIMIT) ? {WIDTH{ex_a[MSB]}} : word_t'($signed(ex_a) >>> ex_b);
            OP_SLL:  alu_f = (ex_b >= W_LIMIT) ? '0 : (ex_a << ex_b);
            OP_BEQZ: alu_br = (ex_a == '0);
            OP_BNEZ: alu_br = (ex_a != '0);
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (issue_mul) state_nxt = S_MUL;
            S_MUL:   if (mul_last)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state == S_IDLE);
        mul_last     = (mul_cnt == CW'(WIDTH - 1));
        mul_done     = (state == S_MUL) && mul_last;
        mul_acc_nxt  = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    end

    // One multiplier bit per cycle: accumulate, then shift multiplicand up and multiplier down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
            mul_rd     <= '0;
            mul_wr     <= 1'b0;
        end else if (issue_mul) begin
            mul_acc    <= '0;
            mul_mcand  <= {{WIDTH{1'b0}}, opa};
            mul_mplier <= opb;
            mul_cnt    <= '0;
            mul_rd     <= bus.rd_addr;
            mul_wr     <= issue_wr;
        end else if (state == S_MUL) begin
            mul_acc    <= mul_acc_nxt;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.result      <= '0;
            bus.ovf         <= 1'b0;
            bus.take_branch <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            if (ex_valid) begin
                bus.out_valid   <= 1'b1;
                bus.result      <= alu_f;
                bus.ovf         <= alu_ovf;
                bus.take_branch <= alu_br;
            end else if (mul_done) begin
                bus.out_valid   <= 1'b1;
                bus.result      <= mul_acc_nxt[WIDTH-1:0];
                bus.ovf         <= |mul_acc_nxt[2*WIDTH-1:WIDTH];
                bus.take_branch <= 1'b0;
            end
        end
    end

    // NOTE: the register file is reset explicitly because reset must clear architectural state.
    // The internal writeback is assigned last so it wins a same-register collision with ext_wr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (bus.ext_wr_en && bus.ext_wr_addr != '0)
                regs[bus.ext_wr_addr] <= bus.ext_wr_data;
            if (ex_valid && ex_wr)
                regs[ex_rd] <= alu_f;
            else if (mul_done && mul_wr && mul_rd != '0)
                regs[mul_rd] <= mul_acc_nxt[WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_alu_pipe_datapath.sv
// Directed bench for alu_pipe_datapath: hand-computed vectors for add/sub
// overflow, forwarding, multiply stall, branches, shifts, collisions and reset.
module tb_alu_pipe_datapath;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    alu_pipe_if bus_if ();
    alu_pipe_datapath dut (.clk(clk), .rst(rst), .bus(bus_if));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic wr, input logic s1z,
                             input logic s2i, input logic [15:0] imm_v);
        bus_if.in_valid  = 1'b1;
        bus_if.alu_op    = op;
        bus_if.rd_addr   = rd;
        bus_if.rs1_addr  = rs1;
        bus_if.rs2_addr  = rs2;
        bus_if.wr_en     = wr;
        bus_if.src1_zero = s1z;
        bus_if.src2_imm  = s2i;
        bus_if.imm       = imm_v;
    endtask

    task automatic ext_write(input logic [2:0] addr, input logic [15:0] data);
        bus_if.ext_wr_en   = 1'b1;
        bus_if.ext_wr_addr = addr;
        bus_if.ext_wr_data = data;
        cycle();
        bus_if.ext_wr_en   = 1'b0;
    endtask

    // Issue a single-cycle op and step to its T+2 output cycle.
    task automatic run_op(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic wr, input logic s1z,
                          input logic s2i, input logic [15:0] imm_v);
        set_issue(op, rd, rs1, rs2, wr, s1z, s2i, imm_v);
        cycle();
        bus_if.in_valid = 1'b0;
        cycle();
    endtask

    task automatic read_reg(input logic [2:0] addr, input logic [15:0] exp, input string tag);
        run_op(4'd3, 3'd0, addr, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0000);
        check(tag, bus_if.result, exp);
    endtask

    int low_cycles;
    int pulses;

    initial begin
        bus_if.in_valid = 1'b0; bus_if.alu_op = '0; bus_if.rd_addr = '0;
        bus_if.rs1_addr = '0; bus_if.rs2_addr = '0; bus_if.wr_en = 1'b0;
        bus_if.src1_zero = 1'b0; bus_if.src2_imm = 1'b0; bus_if.imm = '0;
        bus_if.ext_wr_en = 1'b0; bus_if.ext_wr_addr = '0; bus_if.ext_wr_data = '0;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        check("rst_in_ready", bus_if.in_ready, 1);
        check("rst_out_valid", bus_if.out_valid, 0);
        check("rst_result", bus_if.result, 0);
        check("rst_ovf_br", {bus_if.ovf, bus_if.take_branch}, 0);

        // Signed overflow on add, exact T+2 timing.
        ext_write(3'd1, 16'h7FFF);
        ext_write(3'd2, 16'h0001);
        set_issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0);
        cycle();
        bus_if.in_valid = 1'b0;
        check("add_t1_no_valid", bus_if.out_valid, 0);
        cycle();
        check("add_t2_valid", bus_if.out_valid, 1);
        check("add_result", bus_if.result, 16'h8000);
        check("add_ovf", bus_if.ovf, 1);
        cycle();
        check("out_valid_pulse", bus_if.out_valid, 0);
        read_reg(3'd3, 16'h8000, "r3_after_add");
        check("or_no_ovf", bus_if.ovf, 0);

        // Same-cycle ext write bypasses the register array.
        bus_if.ext_wr_en = 1'b1; bus_if.ext_wr_addr = 3'd6; bus_if.ext_wr_data = 16'h1234;
        set_issue(4'd3, 3'd0, 3'd6, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0);
        cycle();
        bus_if.in_valid = 1'b0; bus_if.ext_wr_en = 1'b0;
        cycle();
        check("ext_bypass", bus_if.result, 16'h1234);

        // Back-to-back dependent ops through the forward path.
        ext_write(3'd1, 16'd5);
        ext_write(3'd2, 16'd6);
        set_issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0);
        cycle();
        check("b2b_ready", bus_if.in_ready, 1);
        set_issue(4'd10, 3'd4, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0);
        cycle();
        bus_if.in_valid = 1'b0;
        check("b2b_first", bus_if.result, 16'h000B);
        cycle();
        check("b2b_second_valid", bus_if.out_valid, 1);
        check("b2b_second", bus_if.result, 16'h0006);
        check("b2b_sub_ovf", bus_if.ovf, 0);

        // Multiply with overflow; a held in_valid during the stall must be dropped.
        ext_write(3'd1, 16'h0100);
        ext_write(3'd2, 16'h0100);
        set_issue(4'd9, 3'd5, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0);
        cycle();
        set_issue(4'd3, 3'd7, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 16'h0055);
        low_cycles = 0;
        while (bus_if.in_ready == 1'b0 && low_cycles < 40) begin
            low_cycles++;
            if (low_cycles == 4) bus_if.in_valid = 1'b0;
            cycle();
        end
        check("mul_stall_cycles", low_cycles, 16);
        check("mul_valid", bus_if.out_valid, 1);
        check("mul_result", bus_if.result, 16'h0000);
        check("mul_ovf", bus_if.ovf, 1);
        read_reg(3'd7, 16'h0000, "ignored_issue");

        ext_write(3'd1, 16'd3);
        ext_write(3'd2, 16'd7);
        set_issue(4'd9, 3'd5, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0);
        cycle();
        bus_if.in_valid = 1'b0;
        repeat (16) cycle();
        check("mul2_valid", bus_if.out_valid, 1);
        check("mul2_result", bus_if.result, 16'd21);
        check("mul2_ovf", bus_if.ovf, 0);
        read_reg(3'd5, 16'd21, "mul2_writeback");

        // Branches and shift boundaries.
        run_op(4'd6, 3'd6, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("beqz_r0", bus_if.take_branch, 1);
        check("beqz_result", bus_if.result, 0);
        read_reg(3'd6, 16'h1234, "branch_no_wb");
        check("or_clears_br", bus_if.take_branch, 0);
        run_op(4'd7, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("bnez_nonzero", bus_if.take_branch, 1);
        run_op(4'd6, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("beqz_nonzero", bus_if.take_branch, 0);
        ext_write(3'd1, 16'h8000);
        run_op(4'd4, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 16'd20);
        check("sra_big", bus_if.result, 16'hFFFF);
        run_op(4'd4, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 16'd4);
        check("sra_4", bus_if.result, 16'hF800);
        ext_write(3'd1, 16'h0001);
        run_op(4'd5, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 16'd16);
        check("sll_16", bus_if.result, 16'h0000);
        run_op(4'd5, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 16'd15);
        check("sll_15", bus_if.result, 16'h8000);

        // Register 0 and write collisions.
        run_op(4'd3, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 16'hABCD);
        read_reg(3'd0, 16'h0000, "r0_alu_write");
        ext_write(3'd0, 16'hBEEF);
        read_reg(3'd0, 16'h0000, "r0_ext_write");
        set_issue(4'd3, 3'd5, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 16'h00AA);
        cycle();
        bus_if.in_valid = 1'b0;
        ext_write(3'd5, 16'h5555);
        read_reg(3'd5, 16'h00AA, "collision_internal_wins");

        // Reset in cycle 8 of a multiply.
        ext_write(3'd1, 16'd3);
        ext_write(3'd2, 16'd7);
        set_issue(4'd9, 3'd4, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0);
        cycle();
        bus_if.in_valid = 1'b0;
        repeat (7) cycle();
        rst = 1'b1;
        #1;
        check("rst_mid_result", bus_if.result, 0);
        check("rst_mid_flags", {bus_if.out_valid, bus_if.ovf, bus_if.take_branch}, 0);
        cycle();
        rst = 1'b0;
        #1;
        check("rst_mid_ready", bus_if.in_ready, 1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (bus_if.out_valid) pulses++;
        end
        check("rst_mid_no_result", pulses, 0);
        read_reg(3'd4, 16'h0000, "rst_mid_no_wb");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
